// File: rtl/rf_cmd_ctrl.sv
// Command sequencer: turns UART RX byte frames (AA addr data / BB addr) into
// register-file writes and reads, and forwards read data to the UART TX.
module rf_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WIDTH-1:0] RF_RdData,
  input  logic                  RF_RdData_Valid,
  input  logic                  TX_BUSY,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  CMD_ERR
);

  localparam logic [DATA_WIDTH-1:0] OP_WR = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD = DATA_WIDTH'(8'hBB);
  localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } state_t;

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic                  wr_en_s, rd_en_s, tx_vld_s, err_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [DATA_WIDTH-1:0] wdata_s, txdata_s;
  logic                  addr_ok_s;

  // Upper address bits must be zero, otherwise the address byte is rejected.
  assign addr_ok_s = ((RX_P_DATA >> ADDR_WIDTH) == {DATA_WIDTH{1'b0}});

  // FSM state and read-timeout counter registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    wr_en_s  = 1'b0;
    rd_en_s  = 1'b0;
    tx_vld_s = 1'b0;
    err_s    = 1'b0;
    addr_s   = RF_Address;
    wdata_s  = RF_WrData;
    txdata_s = TX_P_DATA;
    case (state_r)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == OP_WR) begin
            state_s = WR_ADDR;
          end else if (RX_P_DATA == OP_RD) begin
            state_s = RD_ADDR;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WR_ADDR, RD_ADDR: begin
        if (RX_D_VLD) begin
          if (!addr_ok_s) begin
            err_s   = 1'b1;
            state_s = IDLE;
          end else if (state_r == WR_ADDR) begin
            addr_s  = RX_P_DATA[ADDR_WIDTH-1:0];
            state_s = WR_DATA;
          end else begin
            addr_s  = RX_P_DATA[ADDR_WIDTH-1:0];
            rd_en_s = 1'b1;
            cnt_s   = {CNT_W{1'b0}};
            state_s = RD_WAIT;
          end
        end else begin
          state_s = state_r;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wdata_s = RX_P_DATA;
          wr_en_s = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = WR_DATA;
        end
      end
      RD_WAIT: begin
        // A byte landing here is dropped; the read keeps waiting.
        err_s = RX_D_VLD;
        if (RF_RdData_Valid) begin
          txdata_s = RF_RdData;
          state_s  = TX_SEND;
        end else if (cnt_r == CNT_LAST) begin
          err_s   = 1'b1;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      TX_SEND: begin
        err_s = RX_D_VLD;
        if (!TX_BUSY) begin
          tx_vld_s = 1'b1;
          state_s  = IDLE;
        end else begin
          state_s = TX_SEND;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      RF_Address <= {ADDR_WIDTH{1'b0}};
      RF_WrData  <= {DATA_WIDTH{1'b0}};
      TX_P_DATA  <= {DATA_WIDTH{1'b0}};
      TX_D_VLD   <= 1'b0;
      CMD_ERR    <= 1'b0;
    end else begin
      RF_WrEn    <= wr_en_s;
      RF_RdEn    <= rd_en_s;
      RF_Address <= addr_s;
      RF_WrData  <= wdata_s;
      TX_P_DATA  <= txdata_s;
      TX_D_VLD   <= tx_vld_s;
      CMD_ERR    <= err_s;
    end
  end

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Table-driven bench for rf_cmd_ctrl: one record per clock cycle holding the
// inputs driven in that cycle and the registered outputs expected after its edge.
module tb_rf_cmd_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_DATA = 8'h00;
  logic       RX_D_VLD = 1'b0;
  logic [7:0] RF_RdData = 8'h00;
  logic       RF_RdData_Valid = 1'b0;
  logic       TX_BUSY = 1'b0;
  logic       RF_WrEn, RF_RdEn, TX_D_VLD, CMD_ERR;
  logic [3:0] RF_Address;
  logic [7:0] RF_WrData, TX_P_DATA;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic       rxv;
    logic [7:0] rx;
    logic       rdv;
    logic [7:0] rdd;
    logic       busy;
    logic [23:0] exp;  // {wr, rd, addr, wdata, txdata, txv, err}
  } vec_t;

  vec_t vecs[$];

  rf_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RD_TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_RdData(RF_RdData), .RF_RdData_Valid(RF_RdData_Valid),
    .TX_BUSY(TX_BUSY),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
    .RF_Address(RF_Address), .RF_WrData(RF_WrData),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic add(input string name, input logic rxv, input logic [7:0] rx,
                     input logic rdv, input logic [7:0] rdd, input logic busy,
                     input logic wr, input logic rd, input logic [3:0] a,
                     input logic [7:0] w, input logic [7:0] t, input logic txv,
                     input logic err);
    vec_t v;
    v.name = name; v.rxv = rxv; v.rx = rx; v.rdv = rdv; v.rdd = rdd; v.busy = busy;
    v.exp = {wr, rd, a, w, t, txv, err};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [23:0] exp);
    logic [23:0] got;
    got = {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, TX_P_DATA, TX_D_VLD, CMD_ERR};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got wr=%b rd=%b addr=%h wd=%h txd=%h txv=%b err=%b, expected wr=%b rd=%b addr=%h wd=%h txd=%h txv=%b err=%b",
               name, got[23], got[22], got[21:18], got[17:10], got[9:2], got[1], got[0],
               exp[23], exp[22], exp[21:18], exp[17:10], exp[9:2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic rxv, input logic [7:0] rx, input logic rdv,
                       input logic [7:0] rdd, input logic busy);
    RX_D_VLD = rxv; RX_P_DATA = rx; RF_RdData_Valid = rdv; RF_RdData = rdd; TX_BUSY = busy;
  endtask

  initial begin
    // name        rxv rx    rdv rdd   bsy  wr rd A     W      T      txv err
    add("wr_op",    1, 8'hAA, 0, 8'h00, 0,  0, 0, 4'h0, 8'h00, 8'h00, 0, 0);
    add("wr_addr",  1, 8'h05, 0, 8'h00, 0,  0, 0, 4'h5, 8'h00, 8'h00, 0, 0);
    add("wr_data",  1, 8'h3C, 0, 8'h00, 0,  1, 0, 4'h5, 8'h3C, 8'h00, 0, 0);
    add("wr_done",  0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h5, 8'h3C, 8'h00, 0, 0);
    add("rd_op",    1, 8'hBB, 0, 8'h00, 0,  0, 0, 4'h5, 8'h3C, 8'h00, 0, 0);
    add("rd_addr",  1, 8'h02, 0, 8'h00, 0,  0, 1, 4'h2, 8'h3C, 8'h00, 0, 0);
    add("rd_wait",  0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h2, 8'h3C, 8'h00, 0, 0);
    add("rd_vld",   0, 8'h00, 1, 8'h81, 0,  0, 0, 4'h2, 8'h3C, 8'h81, 0, 0);
    add("tx_go",    0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h2, 8'h3C, 8'h81, 1, 0);
    add("tx_done",  0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h2, 8'h3C, 8'h81, 0, 0);
    add("rdb_op",   1, 8'hBB, 0, 8'h00, 1,  0, 0, 4'h2, 8'h3C, 8'h81, 0, 0);
    add("rdb_addr", 1, 8'h02, 0, 8'h00, 1,  0, 1, 4'h2, 8'h3C, 8'h81, 0, 0);
    add("rdb_wait", 0, 8'h00, 0, 8'h00, 1,  0, 0, 4'h2, 8'h3C, 8'h81, 0, 0);
    add("rdb_vld",  0, 8'h00, 1, 8'h5A, 1,  0, 0, 4'h2, 8'h3C, 8'h5A, 0, 0);
    for (int i = 0; i < 8; i++)
      add("tx_busy", 0, 8'h00, 0, 8'h00, 1, 0, 0, 4'h2, 8'h3C, 8'h5A, 0, 0);
    add("tx_free",  0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h2, 8'h3C, 8'h5A, 1, 0);
    add("tx_once",  0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h2, 8'h3C, 8'h5A, 0, 0);
    add("bad_op",   1, 8'h55, 0, 8'h00, 0,  0, 0, 4'h2, 8'h3C, 8'h5A, 0, 1);
    add("bad_op_e", 0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h2, 8'h3C, 8'h5A, 0, 0);
    add("wr_op2",   1, 8'hAA, 0, 8'h00, 0,  0, 0, 4'h2, 8'h3C, 8'h5A, 0, 0);
    add("bad_addr", 1, 8'h13, 0, 8'h00, 0,  0, 0, 4'h2, 8'h3C, 8'h5A, 0, 1);
    add("bad_ad_e", 0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h2, 8'h3C, 8'h5A, 0, 0);
    add("to_op",    1, 8'hBB, 0, 8'h00, 0,  0, 0, 4'h2, 8'h3C, 8'h5A, 0, 0);
    add("to_addr",  1, 8'h01, 0, 8'h00, 0,  0, 1, 4'h1, 8'h3C, 8'h5A, 0, 0);
    for (int i = 0; i < 3; i++)
      add("to_wait", 0, 8'h00, 0, 8'h00, 0, 0, 0, 4'h1, 8'h3C, 8'h5A, 0, 0);
    add("to_err",   0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h1, 8'h3C, 8'h5A, 0, 1);
    add("to_late",  0, 8'h00, 1, 8'hEE, 0,  0, 0, 4'h1, 8'h3C, 8'h5A, 0, 0);
    add("dr_op",    1, 8'hBB, 0, 8'h00, 0,  0, 0, 4'h1, 8'h3C, 8'h5A, 0, 0);
    add("dr_addr",  1, 8'h03, 0, 8'h00, 0,  0, 1, 4'h3, 8'h3C, 8'h5A, 0, 0);
    add("dr_wait",  0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h3, 8'h3C, 8'h5A, 0, 0);
    add("dr_vld",   0, 8'h00, 1, 8'hC3, 1,  0, 0, 4'h3, 8'h3C, 8'hC3, 0, 0);
    add("dr_byte",  1, 8'h77, 0, 8'h00, 1,  0, 0, 4'h3, 8'h3C, 8'hC3, 0, 1);
    add("dr_hold",  0, 8'h00, 0, 8'h00, 1,  0, 0, 4'h3, 8'h3C, 8'hC3, 0, 0);
    add("dr_tx",    0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h3, 8'h3C, 8'hC3, 1, 0);
    add("dr_done",  0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h3, 8'h3C, 8'hC3, 0, 0);
    add("bb_op",    1, 8'hAA, 0, 8'h00, 0,  0, 0, 4'h3, 8'h3C, 8'hC3, 0, 0);
    add("bb_addr",  1, 8'h0F, 0, 8'h00, 0,  0, 0, 4'hF, 8'h3C, 8'hC3, 0, 0);
    add("bb_data",  1, 8'hA5, 0, 8'h00, 0,  1, 0, 4'hF, 8'hA5, 8'hC3, 0, 0);
    add("bb_op2",   1, 8'hAA, 0, 8'h00, 0,  0, 0, 4'hF, 8'hA5, 8'hC3, 0, 0);
    add("bb_addr2", 1, 8'h00, 0, 8'h00, 0,  0, 0, 4'h0, 8'hA5, 8'hC3, 0, 0);
    add("bb_data2", 1, 8'h11, 0, 8'h00, 0,  1, 0, 4'h0, 8'h11, 8'hC3, 0, 0);
    add("bb_end",   0, 8'h00, 0, 8'h00, 0,  0, 0, 4'h0, 8'h11, 8'hC3, 0, 0);

    #2;
    check("reset", 24'h000000);
    @(posedge CLK); #1;
    RST = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].rxv, vecs[i].rx, vecs[i].rdv, vecs[i].rdd, vecs[i].busy);
      @(posedge CLK); #1;
      check(vecs[i].name, vecs[i].exp);
    end

    // Reset in the middle of a write frame, after opcode and address.
    drive(1'b1, 8'hAA, 1'b0, 8'h00, 1'b0);
    @(posedge CLK); #1;
    drive(1'b1, 8'h07, 1'b0, 8'h00, 1'b0);
    @(posedge CLK); #1;
    check("mid_addr", {1'b0, 1'b0, 4'h7, 8'h11, 8'hC3, 1'b0, 1'b0});
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #2 RST = 1'b0;
    #1 check("mid_reset", 24'h000000);
    @(posedge CLK); #1;
    check("reset_hold", 24'h000000);
    RST = 1'b1;
    drive(1'b1, 8'h09, 1'b0, 8'h00, 1'b0);
    @(posedge CLK); #1;
    check("post_rst_09", {1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1});
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    @(posedge CLK); #1;
    check("post_rst_end", 24'h000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
